// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_target_pkg;

   localparam int BITS_PER_BYTE = 8;

   typedef logic [BITS_PER_BYTE-1:0] spi_byte_t;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } spi_target_state_e;

endpackage

// File: rtl/spi_target_fifo.sv
// Synchronous byte FIFO for the rx path; push while full is accepted when a pop happens
// in the same cycle. DEPTH must be a power of two (>= 2).
module spi_target_fifo
   import spi_target_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  spi_byte_t push_data,
   input  logic      pop,
   output spi_byte_t pop_data,
   output logic      full,
   output logic      empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   spi_byte_t        mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target oversampled in io_clock. Define SPI_TARGET_RX_FIFO_EN to replace the
// single rx holding register with an RX_FIFO_DEPTH-entry FIFO.
module spi_target
   import spi_target_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter spi_byte_t   FILL_BYTE     = 8'hFF,
   parameter int unsigned RX_FIFO_DEPTH = 4
) (
   input  logic      io_clock,
   input  logic      io_reset,
   input  logic      io_spi_sclk,
   input  logic      io_spi_ss,
   input  logic      io_spi_mosi,
   output logic      io_spi_miso,
   output logic      io_spi_miso_oe,
   output spi_byte_t io_rx_data,
   output logic      io_rx_valid,
   input  logic      io_rx_ready,
   input  spi_byte_t io_tx_data,
   input  logic      io_tx_valid,
   output logic      io_tx_ready,
   output logic      io_busy,
   output logic      io_rx_overflow,
   output logic      io_frame_abort
);

   if (SYNC_STAGES < 2) begin : gen_sync_check
      $error("SYNC_STAGES must be at least 2");
   end
   if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : gen_depth_check
      $error("RX_FIFO_DEPTH must be a power of two >= 2");
   end

   logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, ss_prev_q;
   logic                   sclk_s, ss_s, mosi_s;
   logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

   spi_target_state_e state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   spi_byte_t         tx_shift_q, tx_shift_d;
   spi_byte_t         rx_shift_q, rx_shift_d;
   spi_byte_t         rx_byte;
   logic              abort_q, abort_d;
   logic              overflow_q;
   logic              load;
   logic              rx_done;
   logic              rx_full;
   logic              rx_pop;

   // Sync chains load the idle bus state so reset never looks like an edge.
   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], io_spi_sclk};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], io_spi_ss};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], io_spi_mosi};
         sclk_prev_q <= sclk_s;
         ss_prev_q   <= ss_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s && !sclk_prev_q;
   assign sclk_fall = !sclk_s && sclk_prev_q;
   assign ss_rise   = ss_s && !ss_prev_q;
   assign ss_fall   = !ss_s && ss_prev_q;
   assign rx_byte   = {rx_shift_q[BITS_PER_BYTE-2:0], mosi_s};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      abort_d    = 1'b0;
      load       = 1'b0;
      rx_done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d   = ST_SHIFT;
               bit_cnt_d = '0;
               load      = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (ss_rise) begin
               state_d    = ST_IDLE;
               abort_d    = (bit_cnt_q != '0);
               bit_cnt_d  = '0;
               tx_shift_d = FILL_BYTE;
            end else if (sclk_rise) begin
               rx_shift_d = rx_byte;
               bit_cnt_d  = bit_cnt_q + 3'd1;
               rx_done    = (bit_cnt_q == 3'(BITS_PER_BYTE - 1));
            end else if (sclk_fall) begin
               // A fall with the counter wrapped closes a byte: reload instead of shifting.
               if (bit_cnt_q == '0) load = 1'b1;
               else tx_shift_d = {tx_shift_q[BITS_PER_BYTE-2:0], 1'b0};
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) tx_shift_d = io_tx_valid ? io_tx_data : FILL_BYTE;
   end

   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         tx_shift_q <= FILL_BYTE;
         rx_shift_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         abort_q    <= abort_d;
      end
   end

`ifdef SPI_TARGET_RX_FIFO_EN
   logic rx_empty;

   assign rx_pop      = !rx_empty && io_rx_ready;
   assign io_rx_valid = !rx_empty;

   spi_target_fifo #(
      .DEPTH (RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk       (io_clock),
      .reset     (io_reset),
      .push      (rx_done),
      .push_data (rx_byte),
      .pop       (rx_pop),
      .pop_data  (io_rx_data),
      .full      (rx_full),
      .empty     (rx_empty)
   );
`else
   spi_byte_t rx_data_q;
   logic      rx_valid_q;

   assign rx_full     = rx_valid_q;
   assign rx_pop      = rx_valid_q && io_rx_ready;
   assign io_rx_valid = rx_valid_q;
   assign io_rx_data  = rx_data_q;

   always_ff @(posedge io_clock) begin
      if (io_reset) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else if (rx_done && (!rx_valid_q || rx_pop)) begin
         rx_data_q  <= rx_byte;
         rx_valid_q <= 1'b1;
      end else if (rx_pop) begin
         rx_valid_q <= 1'b0;
      end
   end
`endif

   always_ff @(posedge io_clock) begin
      if (io_reset) overflow_q <= 1'b0;
      else if (rx_done && rx_full && !rx_pop) overflow_q <= 1'b1;
   end

   assign io_spi_miso    = tx_shift_q[BITS_PER_BYTE-1];
   assign io_spi_miso_oe = (state_q == ST_SHIFT);
   assign io_tx_ready    = load && io_tx_valid && !io_reset;
   assign io_busy        = !ss_s;
   assign io_rx_overflow = overflow_q;
   assign io_frame_abort = abort_q;

endmodule
